// File: rtl/monolith_stream_ctrl_if.sv
// AXI-Stream style handshake bundle used for both the raw input stream and the
// digest output stream of the Monolith hash front-end.
interface monolith_stream_ctrl_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/monolith_stream_ctrl.sv
// Stream front-end for a Mersenne-31 hash core: loads a 16-word block, starts the
// core, waits for its result and streams the 16-word digest state back out.
module monolith_stream_ctrl #(
    parameter int unsigned N_WORDS = 16,
    parameter logic [30:0] P       = 31'h7FFFFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    monolith_stream_ctrl_if.slave  s,
    monolith_stream_ctrl_if.master m,
    output logic [N_WORDS*31-1:0]  core_state_in,
    output logic                   core_start,
    input  logic [N_WORDS*31-1:0]  core_state_out,
    input  logic                   core_valid,
    output logic                   busy,
    output logic                   err_frame
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // Fold bit 31 back in (2^31 == 1 mod P), then one conditional subtract.
    function automatic logic [30:0] reduce_m31(input logic [31:0] raw);
        logic [31:0] sum;
        logic [31:0] diff;
        sum  = {1'b0, raw[30:0]} + {31'd0, raw[31]};
        diff = sum - {1'b0, P};
        if (sum >= {1'b0, P}) begin
            reduce_m31 = diff[30:0];
        end else begin
            reduce_m31 = sum[30:0];
        end
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  load_cnt_r;
    logic [3:0]  out_cnt_r;
    logic [3:0]  out_cnt_nxt_s;
    logic [30:0] in_buf_r  [N_WORDS];
    logic [30:0] out_buf_r [N_WORDS];
    logic        s_fire_s;
    logic        m_fire_s;
    logic        cap_s;
    logic        s_tready_r;
    logic        m_tvalid_r;
    logic        m_tlast_r;
    logic [30:0] m_tdata_r;
    logic [30:0] m_tdata_nxt_s;
    logic        m_tlast_nxt_s;
    logic        core_start_r;
    logic        busy_r;
    logic        err_frame_r;

    // Core sees the load buffer directly; it only changes on LOAD writes.
    for (genvar g = 0; g < N_WORDS; g++) begin : g_pack
        assign core_state_in[31*g +: 31] = in_buf_r[g];
    end

    assign s.tready   = s_tready_r;
    assign m.tvalid   = m_tvalid_r;
    assign m.tdata    = m_tdata_r;
    assign m.tlast    = m_tlast_r;
    assign core_start = core_start_r;
    assign busy       = busy_r;
    assign err_frame  = err_frame_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and handshake strobes.
    always_comb begin
        state_nxt_s   = state_r;
        s_fire_s      = 1'b0;
        m_fire_s      = 1'b0;
        cap_s         = 1'b0;
        out_cnt_nxt_s = out_cnt_r;
        case (state_r)
            ST_LOAD: begin
                s_fire_s = s.tvalid & s_tready_r;
                if (s_fire_s && (load_cnt_r == 4'd15)) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                cap_s = core_valid;
                if (core_valid) begin
                    state_nxt_s = ST_UNLOAD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_UNLOAD: begin
                m_fire_s = m_tvalid_r & m.tready;
                if (m_fire_s) begin
                    out_cnt_nxt_s = out_cnt_r + 4'd1;
                    if (out_cnt_r == 4'd15) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_UNLOAD;
                    end
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // Next output word; on capture the buffer is not yet written, so bypass it.
    always_comb begin
        m_tdata_nxt_s = 31'd0;
        m_tlast_nxt_s = 1'b0;
        if (cap_s) begin
            m_tdata_nxt_s = core_state_out[30:0];
            m_tlast_nxt_s = 1'b0;
        end else if (state_nxt_s == ST_UNLOAD) begin
            m_tdata_nxt_s = out_buf_r[out_cnt_nxt_s];
            m_tlast_nxt_s = (out_cnt_nxt_s == 4'd15);
        end else begin
            m_tdata_nxt_s = 31'd0;
            m_tlast_nxt_s = 1'b0;
        end
    end

    // Buffers, counters and the sticky framing flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_r  <= 4'd0;
            out_cnt_r   <= 4'd0;
            err_frame_r <= 1'b0;
            for (int i = 0; i < int'(N_WORDS); i++) begin
                in_buf_r[i]  <= 31'd0;
                out_buf_r[i] <= 31'd0;
            end
        end else begin
            if (s_fire_s) begin
                in_buf_r[load_cnt_r] <= reduce_m31(s.tdata);
                load_cnt_r           <= load_cnt_r + 4'd1;
                if (s.tlast != (load_cnt_r == 4'd15)) begin
                    err_frame_r <= 1'b1;
                end
            end
            if (cap_s) begin
                for (int i = 0; i < int'(N_WORDS); i++) begin
                    out_buf_r[i] <= core_state_out[31*i +: 31];
                end
            end
            out_cnt_r <= out_cnt_nxt_s;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_tready_r   <= 1'b1;
            m_tvalid_r   <= 1'b0;
            m_tdata_r    <= 31'd0;
            m_tlast_r    <= 1'b0;
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            s_tready_r   <= (state_nxt_s == ST_LOAD);
            m_tvalid_r   <= (state_nxt_s == ST_UNLOAD);
            m_tdata_r    <= m_tdata_nxt_s;
            m_tlast_r    <= m_tlast_nxt_s;
            core_start_r <= (state_nxt_s == ST_START);
            busy_r       <= (state_nxt_s == ST_START) || (state_nxt_s == ST_WAIT);
        end
    end

endmodule
